// File: rtl/m68k_bus_sequencer_if.sv
// Signal bundle between the Pi register file / Amiga bus and m68k_bus_sequencer.
// master = Pi request side plus bus terminations; slave = the bus sequencer.
interface m68k_bus_sequencer_if;
    logic        mc_clk_rising;
    logic        mc_clk_falling;
    logic        req_start;
    logic        req_rw;
    logic [1:0]  req_size;
    logic [2:0]  req_fc;
    logic [23:0] req_address;
    logic [31:0] req_data_write;
    logic        is_bm;
    logic        dtack_n;
    logic        berr_n;
    logic        vpa_n;
    logic [15:0] d_in;
    logic        req_active;
    logic        req_terminated_normally;
    logic [31:0] req_data_read;
    logic [22:0] a_out;
    logic [15:0] d_out;
    logic [2:0]  fc_out;
    logic        rw_out;
    logic        as_n;
    logic        uds_n;
    logic        lds_n;
    logic        vma_n;
    logic        e_clk;
    logic        abus_drive;
    logic        dbus_drive;
    logic        fc_drive;
    logic        ctrl_drive;

    modport master (
        output mc_clk_rising, mc_clk_falling, req_start, req_rw, req_size, req_fc,
               req_address, req_data_write, is_bm, dtack_n, berr_n, vpa_n, d_in,
        input  req_active, req_terminated_normally, req_data_read, a_out, d_out, fc_out,
               rw_out, as_n, uds_n, lds_n, vma_n, e_clk,
               abus_drive, dbus_drive, fc_drive, ctrl_drive
    );

    modport slave (
        input  mc_clk_rising, mc_clk_falling, req_start, req_rw, req_size, req_fc,
               req_address, req_data_write, is_bm, dtack_n, berr_n, vpa_n, d_in,
        output req_active, req_terminated_normally, req_data_read, a_out, d_out, fc_out,
               rw_out, as_n, uds_n, lds_n, vma_n, e_clk,
               abus_drive, dbus_drive, fc_drive, ctrl_drive
    );
endinterface

// File: rtl/m68k_bus_sequencer.sv
// 68000-compatible bus-cycle sequencer behind the PiStorm16 Pi register interface.
// Define PS16_VPA_CYCLE_EN to build the E clock and VPA/VMA synchronous cycles.
module m68k_bus_sequencer #(
    parameter int TIMEOUT_CLKS = 1024
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    m68k_bus_sequencer_if.slave bus
);
    localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);

    typedef enum logic [3:0] {
        IDLE, WAIT, S0, S1, S2, S3, S4, S5, S6, S7, REJECT
`ifdef PS16_VPA_CYCLE_EN
        , VSYNC
`endif
    } state_t;

    state_t state, next_state;

    logic             rw_l, second_l, term_ok;
    logic [1:0]       size_l;
    logic [2:0]       fc_l;
    logic [23:0]      addr_l;
    logic [31:0]      wdata_l, rd_buf;
    logic [TMO_W-1:0] tmo_cnt;

    logic [22:0] a_out_r;
    logic [15:0] d_out_r;
    logic [2:0]  fc_out_r;
    logic [31:0] rd_data_r;
    logic        status_r;

    logic        rise, fall, bad_req, tmo_hit, long_more, vsync_st, vsync_done;
    logic        in_cycle, as_on, ds_on, data_on, uds_sel, lds_sel;
    logic [23:0] next_addr;
    logic [15:0] wr_word;

    assign rise      = bus.mc_clk_rising;
    assign fall      = bus.mc_clk_falling;
    assign bad_req   = !bus.is_bm || (bus.req_size == 2'd3) ||
                       ((bus.req_size != 2'd0) && bus.req_address[0]);
    assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT_CLKS));
    // A long transfer continues into its second word only after a clean first word.
    assign long_more = (size_l == 2'd2) && !second_l && term_ok;
    assign next_addr = addr_l + 24'd2;
    assign wr_word   = (size_l == 2'd0) ? {2{wdata_l[7:0]}} :
                       ((size_l == 2'd2) && !second_l) ? wdata_l[31:16] : wdata_l[15:0];
    assign uds_sel   = (size_l != 2'd0) || !addr_l[0];
    assign lds_sel   = (size_l != 2'd0) || addr_l[0];

`ifdef PS16_VPA_CYCLE_EN
    logic [3:0] e_cnt;
    logic       vma_on;

    assign vsync_st   = (state == VSYNC);
    assign vsync_done = vsync_st && vma_on && fall && (e_cnt == 4'd9);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            e_cnt  <= 4'd0;
            vma_on <= 1'b0;
        end else begin
            if (rise) e_cnt <= (e_cnt == 4'd9) ? 4'd0 : e_cnt + 4'd1;
            if (!vsync_st)          vma_on <= 1'b0;
            else if (e_cnt == 4'd3) vma_on <= 1'b1;
        end
    end

    assign bus.e_clk = (e_cnt >= 4'd6);
    assign bus.vma_n = !(vsync_st && vma_on);
`else
    assign vsync_st   = 1'b0;
    assign vsync_done = 1'b0;
    assign bus.e_clk  = 1'b0;
    assign bus.vma_n  = 1'b1;
`endif

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (bus.req_start) next_state = bad_req ? REJECT : WAIT;
            WAIT:   if (rise) next_state = S0;
            S0:     if (fall) next_state = S1;
            S1:     if (rise) next_state = S2;
            S2:     if (fall) next_state = S3;
            S3:     if (rise) next_state = S4;
            S4: begin
                // BERR/timeout and DTACK both leave through S5; the status differs.
                if (fall) begin
                    if (!bus.berr_n || tmo_hit || !bus.dtack_n) next_state = S5;
`ifdef PS16_VPA_CYCLE_EN
                    else if (!bus.vpa_n) next_state = VSYNC;
`endif
                end
            end
            S5:     if (rise) next_state = S6;
            S6:     if (fall) next_state = S7;
            S7:     if (rise) next_state = long_more ? S0 : IDLE;
            REJECT: next_state = IDLE;
`ifdef PS16_VPA_CYCLE_EN
            VSYNC:  if (vsync_done) next_state = S7;
`endif
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_cycle = vsync_st;
        as_on    = vsync_st;
        ds_on    = vsync_st;
        data_on  = vsync_st;
        case (state)
            S0, S1: in_cycle = 1'b1;
            S2: begin
                in_cycle = 1'b1;
                as_on    = 1'b1;
                ds_on    = rw_l;
            end
            S3: begin
                in_cycle = 1'b1;
                as_on    = 1'b1;
                ds_on    = rw_l;
                data_on  = 1'b1;
            end
            S4, S5, S6: begin
                in_cycle = 1'b1;
                as_on    = 1'b1;
                ds_on    = 1'b1;
                data_on  = 1'b1;
            end
            S7: begin
                in_cycle = 1'b1;
                data_on  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.abus_drive = in_cycle;
    assign bus.fc_drive   = in_cycle;
    assign bus.ctrl_drive = in_cycle;
    assign bus.dbus_drive = data_on && !rw_l;
    assign bus.rw_out     = !in_cycle || rw_l;
    assign bus.as_n       = !as_on;
    assign bus.uds_n      = !(ds_on && uds_sel);
    assign bus.lds_n      = !(ds_on && lds_sel);
    assign bus.req_active = (state != IDLE);
    assign bus.a_out      = a_out_r;
    assign bus.d_out      = d_out_r;
    assign bus.fc_out     = fc_out_r;
    assign bus.req_data_read           = rd_data_r;
    assign bus.req_terminated_normally = status_r;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            a_out_r   <= '0;
            d_out_r   <= '0;
            fc_out_r  <= '0;
            rd_data_r <= '0;
            status_r  <= 1'b0;
        end else begin
            if ((state == IDLE) && bus.req_start && bad_req) status_r <= 1'b0;
            if ((state == WAIT) && rise) begin
                a_out_r  <= addr_l[23:1];
                fc_out_r <= fc_l;
            end
            if ((state == S2) && fall && !rw_l) d_out_r <= wr_word;
            if ((state == S7) && rise) begin
                if (long_more) begin
                    a_out_r <= next_addr[23:1];
                end else begin
                    status_r <= term_ok;
                    if (term_ok && rw_l) rd_data_r <= rd_buf;
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            second_l <= 1'b0;
            tmo_cnt  <= '0;
        end else begin
            if ((state == IDLE) && bus.req_start)             second_l <= 1'b0;
            else if ((state == S7) && rise && long_more)      second_l <= 1'b1;
            if ((state == S3) && rise)                        tmo_cnt <= '0;
            else if ((state == S4) && rise && !tmo_hit)       tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if ((state == IDLE) && bus.req_start) begin
            rw_l    <= bus.req_rw;
            size_l  <= bus.req_size;
            fc_l    <= bus.req_fc;
            addr_l  <= bus.req_address;
            wdata_l <= bus.req_data_write;
        end else if ((state == S7) && rise && long_more) begin
            addr_l  <= next_addr;
        end
        if ((state == S4) && fall) term_ok <= bus.berr_n && !tmo_hit;
        if (rw_l && (((state == S6) && fall) || vsync_done)) begin
            case (size_l)
                2'd0:    rd_buf <= {24'd0, (addr_l[0] ? bus.d_in[7:0] : bus.d_in[15:8])};
                2'd1:    rd_buf <= {16'd0, bus.d_in};
                default: begin
                    if (second_l) rd_buf[15:0]  <= bus.d_in;
                    else          rd_buf[31:16] <= bus.d_in;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_m68k_bus_sequencer.sv
// Directed self-checking bench for m68k_bus_sequencer (TIMEOUT_CLKS = 8, 7M = 8 sys_clk).
module tb_m68k_bus_sequencer;
    logic sys_clk;
    logic sys_rst_n;

    m68k_bus_sequencer_if bus();

    m68k_bus_sequencer #(.TIMEOUT_CLKS(8)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // responder configuration
    int          waits = 0;
    logic        resp_dtack = 1'b0, resp_berr = 1'b0, resp_vpa = 1'b0;
    logic [15:0] rd_w0 = 16'h0, rd_w1 = 16'h0;

    // monitor results
    int          phase = 7;
    int          falls = 0, ncyc = 0, as_low = 0, periods = 0, active_cycles = 0;
    logic        prev_as = 1'b1, cap_done = 1'b0, term;
    logic        uds_seen = 1'b0, lds_seen = 1'b0, gap_seen = 1'b0, vma_e_seen = 1'b0;
    logic [22:0] a_cap [0:3];
    logic [15:0] d_cap [0:3];

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Strobe generator, bus responder and monitor share one negedge process.
    initial begin
        bus.mc_clk_rising  = 1'b0;
        bus.mc_clk_falling = 1'b0;
        bus.dtack_n        = 1'b1;
        bus.berr_n         = 1'b1;
        bus.vpa_n          = 1'b1;
        bus.d_in           = 16'h0;
        forever begin
            @(negedge sys_clk);
            if (bus.req_active) active_cycles++;
            if (bus.as_n) begin
                falls    = 0;
                cap_done = 1'b0;
            end else begin
                if (prev_as) ncyc++;
                as_low++;
            end
            prev_as = bus.as_n;
            if (!bus.uds_n) uds_seen = 1'b1;
            if (!bus.lds_n) lds_seen = 1'b1;
            if ((!bus.uds_n || !bus.lds_n) && !cap_done && ncyc < 4) begin
                a_cap[ncyc] = bus.a_out;
                d_cap[ncyc] = bus.d_out;
                cap_done    = 1'b1;
            end
            if (ncyc == 1 && bus.as_n && bus.abus_drive && !bus.dbus_drive) gap_seen = 1'b1;
            if (!bus.vma_n && bus.e_clk) vma_e_seen = 1'b1;

            phase = (phase == 7) ? 0 : phase + 1;
            bus.mc_clk_rising  = (phase == 0);
            bus.mc_clk_falling = (phase == 4);
            if (bus.mc_clk_rising && bus.abus_drive) periods++;
            if (!bus.as_n && bus.mc_clk_falling) falls++;
            term        = !bus.as_n && (falls >= 2 + waits);
            bus.dtack_n = !(term && resp_dtack);
            bus.berr_n  = !(term && resp_berr);
            bus.vpa_n   = !(term && resp_vpa);
            bus.d_in    = (ncyc <= 1) ? rd_w0 : rd_w1;
        end
    end

    task automatic set_resp(input int w, input logic dt, input logic be, input logic vp);
        waits      = w;
        resp_dtack = dt;
        resp_berr  = be;
        resp_vpa   = vp;
    endtask

    task automatic start_req(input logic rw, input logic [1:0] size, input logic [2:0] fc,
                             input logic [23:0] addr, input logic [31:0] wd);
        @(negedge sys_clk);
        ncyc = 0; as_low = 0; periods = 0; active_cycles = 0;
        uds_seen = 1'b0; lds_seen = 1'b0; gap_seen = 1'b0; vma_e_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_cap[i] = '0;
            d_cap[i] = '0;
        end
        bus.req_rw         = rw;
        bus.req_size       = size;
        bus.req_fc         = fc;
        bus.req_address    = addr;
        bus.req_data_write = wd;
        bus.req_start      = 1'b1;
        @(negedge sys_clk);
        bus.req_start      = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 800; i++) begin
            if (!bus.req_active) break;
            @(negedge sys_clk);
        end
        chk("req_done", 32'(bus.req_active), 32'h0);
    endtask

    initial begin
        sys_rst_n          = 1'b0;
        bus.req_start      = 1'b0;
        bus.req_rw         = 1'b1;
        bus.req_size       = 2'd0;
        bus.req_fc         = 3'd0;
        bus.req_address    = 24'h0;
        bus.req_data_write = 32'h0;
        bus.is_bm          = 1'b1;
        repeat (4) @(negedge sys_clk);

        chk("rst_drives", 32'({bus.abus_drive, bus.dbus_drive, bus.fc_drive, bus.ctrl_drive}), 32'h0);
        chk("rst_strobes", 32'({bus.as_n, bus.uds_n, bus.lds_n, bus.vma_n, bus.rw_out}), 32'h1f);
        chk("rst_addr_data", 32'({bus.a_out, bus.fc_out}) | 32'(bus.d_out), 32'h0);
        chk("rst_rdata", bus.req_data_read, 32'h0);
        chk("rst_status", 32'({bus.req_active, bus.req_terminated_normally, bus.e_clk}), 32'h0);
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);

        // word read, zero wait states
        set_resp(0, 1'b1, 1'b0, 1'b0);
        rd_w0 = 16'h1234;
        start_req(1'b1, 2'd1, 3'd5, 24'hDFF006, 32'h0);
        wait_idle();
        chk("wr_addr", 32'(bus.a_out), 32'h006FF803);
        chk("wr_fc", 32'(bus.fc_out), 32'h5);
        chk("wr_as_low", 32'(as_low), 32'd20);
        chk("wr_periods", 32'(periods), 32'd4);
        chk("wr_rdata", bus.req_data_read, 32'h00001234);
        chk("wr_status", 32'(bus.req_terminated_normally), 32'h1);
        chk("wr_rw_idle", 32'({bus.rw_out, bus.abus_drive}), 32'h2);

        // long write, two wait states per word
        set_resp(2, 1'b1, 1'b0, 1'b0);
        start_req(1'b0, 2'd2, 3'd1, 24'h000100, 32'hAABBCCDD);
        wait_idle();
        chk("lw_cycles", 32'(ncyc), 32'd2);
        chk("lw_addr0", 32'(a_cap[1]), 32'h80);
        chk("lw_data0", 32'(d_cap[1]), 32'hAABB);
        chk("lw_addr1", 32'(a_cap[2]), 32'h81);
        chk("lw_data1", 32'(d_cap[2]), 32'hCCDD);
        chk("lw_dbus_gap", 32'(gap_seen), 32'h1);
        chk("lw_periods", 32'(periods), 32'd12);
        chk("lw_status", 32'(bus.req_terminated_normally), 32'h1);
        chk("lw_released", 32'({bus.dbus_drive, bus.as_n}), 32'h1);

        // odd-byte write
        set_resp(0, 1'b1, 1'b0, 1'b0);
        start_req(1'b0, 2'd0, 3'd1, 24'h000101, 32'h0000005A);
        wait_idle();
        chk("bw_strobes", 32'({uds_seen, lds_seen}), 32'h1);
        chk("bw_data", 32'(d_cap[1]), 32'h5A5A);
        chk("bw_status", 32'(bus.req_terminated_normally), 32'h1);

        // even-byte read takes D15..8
        rd_w0 = 16'hBEEF;
        start_req(1'b1, 2'd0, 3'd5, 24'h000200, 32'h0);
        wait_idle();
        chk("br_strobes", 32'({uds_seen, lds_seen}), 32'h2);
        chk("br_rdata", bus.req_data_read, 32'h000000BE);

        // odd-address word request is rejected with no bus activity
        start_req(1'b1, 2'd1, 3'd5, 24'h000103, 32'h0);
        wait_idle();
        chk("rej_status", 32'(bus.req_terminated_normally), 32'h0);
        chk("rej_active_cycles", 32'(active_cycles), 32'd1);
        chk("rej_no_strobes", 32'({uds_seen, lds_seen, 2'(ncyc)}), 32'h0);
        chk("rej_rdata", bus.req_data_read, 32'h000000BE);

        // normal long read
        set_resp(0, 1'b1, 1'b0, 1'b0);
        rd_w0 = 16'h1111;
        rd_w1 = 16'h2222;
        start_req(1'b1, 2'd2, 3'd5, 24'h000400, 32'h0);
        wait_idle();
        chk("lr_cycles", 32'(ncyc), 32'd2);
        chk("lr_rdata", bus.req_data_read, 32'h11112222);
        chk("lr_status", 32'(bus.req_terminated_normally), 32'h1);

        // DTACK and BERR together: BERR wins
        set_resp(0, 1'b1, 1'b1, 1'b0);
        rd_w0 = 16'h9999;
        start_req(1'b1, 2'd1, 3'd5, 24'h000500, 32'h0);
        wait_idle();
        chk("db_status", 32'(bus.req_terminated_normally), 32'h0);
        chk("db_rdata", bus.req_data_read, 32'h11112222);

        // odd-byte read takes D7..0
        set_resp(1, 1'b1, 1'b0, 1'b0);
        rd_w0 = 16'h12AB;
        start_req(1'b1, 2'd0, 3'd5, 24'h000301, 32'h0);
        wait_idle();
        chk("obr_rdata", bus.req_data_read, 32'h000000AB);
        chk("obr_status", 32'(bus.req_terminated_normally), 32'h1);

        // BERR on first half of a long read skips the second word
        set_resp(0, 1'b0, 1'b1, 1'b0);
        rd_w0 = 16'h5555;
        rd_w1 = 16'h6666;
        start_req(1'b1, 2'd2, 3'd5, 24'h000600, 32'h0);
        wait_idle();
        chk("lb_cycles", 32'(ncyc), 32'd1);
        chk("lb_status", 32'(bus.req_terminated_normally), 32'h0);
        chk("lb_rdata", bus.req_data_read, 32'h000000AB);

        // no termination: S4 timeout after 8 periods
        set_resp(0, 1'b0, 1'b0, 1'b0);
        start_req(1'b1, 2'd1, 3'd5, 24'h000700, 32'h0);
        wait_idle();
        chk("to_periods", 32'(periods), 32'd12);
        chk("to_as_low", 32'(as_low), 32'd84);
        chk("to_status", 32'(bus.req_terminated_normally), 32'h0);

        // good write then a non-bus-master reject
        set_resp(0, 1'b1, 1'b0, 1'b0);
        start_req(1'b0, 2'd1, 3'd1, 24'h000800, 32'h00004444);
        wait_idle();
        chk("ww_status", 32'(bus.req_terminated_normally), 32'h1);
        bus.is_bm = 1'b0;
        start_req(1'b0, 2'd1, 3'd1, 24'h000800, 32'h00004444);
        wait_idle();
        chk("nbm_status", 32'(bus.req_terminated_normally), 32'h0);
        chk("nbm_cycles", 32'(ncyc), 32'd0);
        bus.is_bm = 1'b1;

        // reset while waiting in S4
        set_resp(0, 1'b0, 1'b0, 1'b0);
        start_req(1'b1, 2'd1, 3'd5, 24'h000900, 32'h0);
        for (int i = 0; i < 200; i++) begin
            if (falls >= 2) break;
            @(negedge sys_clk);
        end
        chk("s4_reached", 32'({bus.as_n, bus.uds_n, bus.abus_drive}), 32'h1);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        chk("mid_rst_drives", 32'({bus.abus_drive, bus.dbus_drive, bus.fc_drive, bus.ctrl_drive}), 32'h0);
        chk("mid_rst_strobes", 32'({bus.as_n, bus.uds_n, bus.lds_n, bus.vma_n, bus.rw_out}), 32'h1f);
        chk("mid_rst_active", 32'(bus.req_active), 32'h0);
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);

`ifdef PS16_VPA_CYCLE_EN
        // VPA synchronous read
        set_resp(0, 1'b0, 1'b0, 1'b1);
        rd_w0 = 16'h4321;
        start_req(1'b1, 2'd1, 3'd5, 24'h00BFE0, 32'h0);
        wait_idle();
        chk("vpa_rdata", bus.req_data_read, 32'h00004321);
        chk("vpa_status", 32'(bus.req_terminated_normally), 32'h1);
        chk("vpa_vma_e_high", 32'(vma_e_seen), 32'h1);
        chk("vpa_vma_idle", 32'(bus.vma_n), 32'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
